clock_display_driver: RTL and testbench

CLOCK_DISPLAY_DRIVER -- requirements
Module: clock_display_driver

---
 rtl/clock_pkg.sv | 48 ++++
 rtl/bin2bcd6_seq.sv | 52 +++++
 rtl/clock_display_driver.sv | 138 +++++++++++++
 tb/tb_clock_display_driver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock display driver: FSM states, segment codes,
// display geometry and a BCD-to-segment helper.
// Ports: none (package).
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int         NUM_DIGITS = 4;
  localparam int         BIN_W      = 6;
  localparam logic [5:0] MAX_VAL    = 6'd59;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd6_seq.sv
// Sequential 6-bit binary to 2-digit BCD converter (double-dabble, one step per edge).
// Ports: clk, reset (async high); start_i loads bin_i; done_o is high during the
// cycle whose rising edge performs the final (6th) step; tens_o/ones_o valid after it.
module bin2bcd6_seq
  import clock_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o
);

  // Shift register layout: {tens[3:0], ones[3:0], bin[5:0]}.
  logic [13:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  tens_adj, ones_adj;
  logic [13:0] adj;

  always_comb begin
    tens_adj = (sr_q[13:10] >= 4'd5) ? sr_q[13:10] + 4'd3 : sr_q[13:10];
    ones_adj = (sr_q[9:6]   >= 4'd5) ? sr_q[9:6]   + 4'd3 : sr_q[9:6];
    adj      = {tens_adj, ones_adj, sr_q[5:0]};
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      sr_d  = {8'd0, bin_i};
      cnt_d = 3'd6;
    end else if (cnt_q != 3'd0) begin
      sr_d  = adj << 1;
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // Flag the last step early so the parent FSM leaves CONV on that same edge.
  assign done_o = (cnt_q == 3'd1);
  assign tens_o = sr_q[13:10];
  assign ones_o = sr_q[9:6];

endmodule

// File: rtl/clock_display_driver.sv
// Converts binary mm:ss to BCD and multiplexes it onto a 4-digit 7-segment display.
// Ports: clk, reset (async high); seconds/minutes binary in; seg/an/dp registered
// display drive; busy during conversion; range_err sticky on an input above 59.
module clock_display_driver
  import clock_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy,
  output logic       range_err
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  state_e                          state_q, state_d;
  logic [11:0]                     last_req_q, last_req_d;
  logic [NUM_DIGITS-1:0][3:0]      dig_q, dig_d;
  logic                            sec_dash_q, sec_dash_d, min_dash_q, min_dash_d;
  logic                            colon_q, colon_d, rerr_q, rerr_d;
  logic [15:0]                     presc_q, presc_d;
  logic [1:0]                      idx_q, idx_d;
  logic [6:0]                      seg_q, seg_d, seg_nxt;
  logic [3:0]                      an_q, an_d;
  logic                            dp_q, dp_d;
  logic                            start, tc, cur_dash;
  logic                            sec_done, min_done;
  logic [3:0]                      sec_tens, sec_ones, min_tens, min_ones, cur_dig;

  bin2bcd6_seq u_sec (
    .clk(clk), .reset(reset), .start_i(start), .bin_i(seconds),
    .done_o(sec_done), .tens_o(sec_tens), .ones_o(sec_ones)
  );

  bin2bcd6_seq u_min (
    .clk(clk), .reset(reset), .start_i(start), .bin_i(minutes),
    .done_o(min_done), .tens_o(min_tens), .ones_o(min_ones)
  );

  // Conversion control. last_req only moves in IDLE, so at COMMIT it still
  // holds exactly the values that were loaded into the converters.
  always_comb begin
    state_d    = state_q;
    last_req_d = last_req_q;
    dig_d      = dig_q;
    sec_dash_d = sec_dash_q;
    min_dash_d = min_dash_q;
    colon_d    = colon_q;
    rerr_d     = rerr_q;
    start      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ({minutes, seconds} != last_req_q) begin
          start      = 1'b1;
          last_req_d = {minutes, seconds};
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        if (sec_done && min_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        dig_d      = {min_tens, min_ones, sec_tens, sec_ones};
        sec_dash_d = (last_req_q[5:0] > MAX_VAL);
        min_dash_d = (last_req_q[11:6] > MAX_VAL);
        rerr_d     = rerr_q | sec_dash_d | min_dash_d;
        colon_d    = ~colon_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan: outputs only reload at the prescaler terminal count, so a commit on
  // the same edge is picked up by the following refresh.
  always_comb begin
    tc       = (presc_q == PRESC_LAST);
    presc_d  = tc ? 16'd0 : presc_q + 16'd1;
    idx_d    = tc ? idx_q + 2'd1 : idx_q;
    cur_dig  = dig_q[idx_q];
    cur_dash = idx_q[1] ? min_dash_q : sec_dash_q;
    if (cur_dash)                                          seg_nxt = SEG_DASH;
    else if (BLANK_LZ && idx_q == 2'd3 && cur_dig == 4'd0) seg_nxt = SEG_BLANK;
    else                                                   seg_nxt = seg_of(cur_dig);
    seg_d = seg_q;
    an_d  = an_q;
    dp_d  = dp_q;
    if (tc) begin
      seg_d = seg_nxt;
      an_d  = ~(4'b0001 << idx_q);
      dp_d  = (idx_q == 2'd2) && colon_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_req_q <= '0;
      dig_q      <= '0;
      sec_dash_q <= 1'b0;
      min_dash_q <= 1'b0;
      colon_q    <= 1'b0;
      rerr_q     <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'b1111;
      dp_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_req_q <= last_req_d;
      dig_q      <= dig_d;
      sec_dash_q <= sec_dash_d;
      min_dash_q <= min_dash_d;
      colon_q    <= colon_d;
      rerr_q     <= rerr_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign busy      = (state_q != ST_IDLE);
  assign range_err = rerr_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Self-checking bench for clock_display_driver: scoreboard of expected scan frames.
// Latency: checks busy run lengths around each conversion.
// Backpressure: none; all waits are cycle-bounded.
module tb_clock_display_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] seconds, minutes;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp, busy, range_err;

  int errors = 0;
  int checks = 0;
  logic [11:0] sb_q[$];   // {an, seg, dp}
  logic        colon_exp;
  logic [6:0]  seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  clock_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes),
    .seg(seg), .an(an), .dp(dp), .busy(busy), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected frames for digit indices 0..3 from a plain decimal model.
  task automatic push_display(input int mins, input int secs);
    int v, d;
    logic [6:0] s;
    logic [3:0] a;
    logic       p;
    for (int i = 0; i < 4; i++) begin
      v = (i < 2) ? secs : mins;
      d = (i % 2 == 0) ? (v % 10) : (v / 10);
      if (v > 59)                    s = 7'h40;
      else if (i == 3 && d == 0)     s = 7'h00;
      else                           s = seg_tbl[d];
      a = 4'b1111;
      a[i] = 1'b0;
      p = (i == 2) ? colon_exp : 1'b0;
      sb_q.push_back({a, s, p});
    end
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic measure_run(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic scan_check(input string tag);
    int n;
    logic [11:0] e;
    n = 0;
    while (an == 4'b1110 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (an != 4'b1110 && n < 40) begin @(negedge clk); n++; end
    for (int k = 0; k < 4; k++) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        return;
      end
      e = sb_q.pop_front();
      n = 0;
      while (an != e[11:8] && n < 40) begin @(negedge clk); n++; end
      chk({tag, "_an"},  {28'd0, an},  {28'd0, e[11:8]});
      chk({tag, "_seg"}, {25'd0, seg}, {25'd0, e[7:1]});
      chk({tag, "_dp"},  {31'd0, dp},  {31'd0, e[0]});
    end
  endtask

  task automatic convert(input string tag, input int mins, input int secs);
    int n;
    minutes = 6'(mins);
    seconds = 6'(secs);
    wait_busy(tag);
    measure_run(n);
    chk({tag, "_busy_len"}, n, 7);
    colon_exp = ~colon_exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g;
    logic busy_seen;
    reset = 1'b1; seconds = '0; minutes = '0; colon_exp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg",  {25'd0, seg},       32'h00);
    chk("rst_an",   {28'd0, an},        32'hF);
    chk("rst_dp",   {31'd0, dp},        32'd0);
    chk("rst_busy", {31'd0, busy},      32'd0);
    chk("rst_rerr", {31'd0, range_err}, 32'd0);
    reset = 1'b0;

    // 00:00 matches the cleared request: no conversion, scan still runs.
    busy_seen = 1'b0;
    repeat (20) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
    chk("no_conv_0000", {31'd0, busy_seen}, 32'd0);
    push_display(0, 0);
    scan_check("d0000");

    convert("c1234", 12, 34);
    push_display(12, 34);
    scan_check("d1234");

    // Both fields change on one edge: exactly one conversion.
    convert("c0959", 9, 59);
    convert("c1000", 10, 0);
    busy_seen = 1'b0;
    repeat (20) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
    chk("one_conv_1000", {31'd0, busy_seen}, 32'd0);
    push_display(10, 0);
    scan_check("d1000");

    // Change during CONV is queued and converted right after the commit.
    seconds = 6'd5;
    wait_busy("c1005");
    @(negedge clk);
    @(negedge clk);
    seconds = 6'd6;
    measure_run(n);
    chk("c1005_run", n, 5);
    g = 0;
    while (!busy && g < 30) begin g++; @(negedge clk); end
    chk("c1006_gap", g, 1);
    measure_run(n);
    chk("c1006_run", n, 7);
    colon_exp = ~colon_exp;
    colon_exp = ~colon_exp;
    push_display(10, 6);
    scan_check("d1006");

    convert("c0007", 0, 7);
    push_display(0, 7);
    scan_check("d0007");

    convert("c0063", 0, 63);
    chk("rerr_set", {31'd0, range_err}, 32'd1);
    push_display(0, 63);
    scan_check("d0063");

    convert("c0010", 0, 10);
    push_display(0, 10);
    scan_check("d0010");
    chk("rerr_sticky", {31'd0, range_err}, 32'd1);

    // Reset in the 3rd CONV cycle aborts; reconversion after release.
    minutes = 6'd12;
    seconds = 6'd34;
    wait_busy("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_seg",  {25'd0, seg},       32'h00);
    chk("abort_an",   {28'd0, an},        32'hF);
    chk("abort_busy", {31'd0, busy},      32'd0);
    chk("abort_rerr", {31'd0, range_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    colon_exp = 1'b0;
    wait_busy("re1234");
    measure_run(n);
    chk("re1234_busy_len", n, 7);
    colon_exp = ~colon_exp;
    push_display(12, 34);
    scan_check("dre1234");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
